// File: rtl/alu_scoreboard_if.sv
// rtl/alu_scoreboard_if.sv - stimulus and response bus between ALU test driver and scoreboard
interface alu_scoreboard_if #(parameter int n = 8);
  logic         stim_valid;
  logic         stim_ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [2:0]   opcode;
  logic         rsp_valid;
  logic [n:0]   result;

  modport master (
    output stim_valid, a, b, opcode, rsp_valid, result,
    input  stim_ready
  );

  modport slave (
    input  stim_valid, a, b, opcode, rsp_valid, result,
    output stim_ready
  );
endinterface

// File: rtl/alu_scoreboard.sv
// rtl/alu_scoreboard.sv - ALU result scoreboard with expected-value FIFO and pass/fail counters
// Optional first-mismatch capture ports enabled by macro ALU_SB_FIRST_FAIL_EN.
module alu_scoreboard #(
  parameter int n     = 8,
  parameter int DEPTH = 4,
  parameter int COUNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_scoreboard_if.slave   bus,
  output logic [15:0]       num_matches,
  output logic [15:0]       num_miss_matches,
  output logic              done,
  output logic              pass,
  output logic              underflow
`ifdef ALU_SB_FIRST_FAIL_EN
  ,
  output logic              fail_valid,
  output logic [n:0]        fail_expected,
  output logic [n:0]        fail_result,
  output logic [15:0]       fail_index
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [n:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;

  logic          full, empty, push, pop, under_evt, hit, miss_evt;
  logic [n:0]    head, expected;
  logic [15:0]   match_n, miss_n;
  logic [16:0]   total_n;

  function automatic logic [n:0] calc(input logic [n-1:0] x, input logic [n-1:0] y,
                                      input logic [2:0] op);
    case (op)
      3'b000:  calc = {1'b0, x} + {1'b0, y};
      3'b001:  calc = {1'b0, x} - {1'b0, y};
      3'b010:  calc = {1'b0, x & y};
      3'b011:  calc = {1'b0, x | y};
      3'b100:  calc = {1'b0, x ^ y};
      3'b101:  calc = {1'b0, ~x};
      3'b110:  calc = {x, 1'b0};
      default: calc = {1'b0, x >> 1};
    endcase
  endfunction

  assign full           = (occ == (PW+1)'(DEPTH));
  assign empty          = (occ == '0);
  assign bus.stim_ready = !full && (state == RUN);
  assign push           = bus.stim_valid && bus.stim_ready;
  assign pop            = (state == RUN) && bus.rsp_valid && !empty;
  assign under_evt      = (state == RUN) && bus.rsp_valid && empty;
  assign head           = mem[rd_ptr];
  assign expected       = calc(bus.a, bus.b, bus.opcode);
  assign hit            = pop && (head == bus.result);
  assign miss_evt       = (pop && !hit) || under_evt;

  always_comb begin
    match_n = num_matches;
    miss_n  = num_miss_matches;
    if (hit && num_matches != 16'hFFFF)
      match_n = num_matches + 16'd1;
    if (miss_evt && num_miss_matches != 16'hFFFF)
      miss_n = num_miss_matches + 16'd1;
    total_n = {1'b0, match_n} + {1'b0, miss_n};
  end

  assign done = (state == DONE);
  assign pass = done && (num_miss_matches == 16'd0) && !underflow;

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= expected;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      num_matches      <= 16'd0;
      num_miss_matches <= 16'd0;
      underflow        <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
      if (state == RUN) begin
        num_matches      <= match_n;
        num_miss_matches <= miss_n;
        if (under_evt)
          underflow <= 1'b1;
      end
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (total_n >= 17'(COUNT)) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SB_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_valid    <= 1'b0;
      fail_expected <= '0;
      fail_result   <= '0;
      fail_index    <= 16'd0;
    end else if (miss_evt && !fail_valid) begin
      fail_valid    <= 1'b1;
      fail_expected <= under_evt ? '0 : head;
      fail_result   <= bus.result;
      fail_index    <= num_matches + num_miss_matches;
    end
  end
`endif

endmodule

// File: tb/tb_alu_scoreboard.sv
// tb/tb_alu_scoreboard.sv - randomized self-checking bench for alu_scoreboard against a queue model
module tb_alu_scoreboard;
  localparam int DEPTH = 4;
  localparam int COUNT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num_matches, num_miss_matches;
  logic        done, pass, underflow;
`ifdef ALU_SB_FIRST_FAIL_EN
  logic        fail_valid;
  logic [8:0]  fail_expected, fail_result;
  logic [15:0] fail_index;
`endif

  alu_scoreboard_if #(.n(8)) bus ();

  alu_scoreboard #(.n(8), .DEPTH(DEPTH), .COUNT(COUNT)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .num_matches      (num_matches),
    .num_miss_matches (num_miss_matches),
    .done             (done),
    .pass             (pass),
    .underflow        (underflow)
`ifdef ALU_SB_FIRST_FAIL_EN
    ,
    .fail_valid       (fail_valid),
    .fail_expected    (fail_expected),
    .fail_result      (fail_result),
    .fail_index       (fail_index)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  int m_match, m_miss;
  bit m_under, m_done, m_run;

  function automatic logic [8:0] ref_alu(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    int ix = x;
    int iy = y;
    int r;
    case (op)
      3'd0: r = ix + iy;
      3'd1: r = (ix - iy + 512) % 512;
      3'd2: r = ix & iy;
      3'd3: r = ix | iy;
      3'd4: r = ix ^ iy;
      3'd5: r = 255 - ix;
      3'd6: r = ix * 2;
      default: r = ix / 2;
    endcase
    return r[8:0];
  endfunction

  function automatic logic [35:0] m_status();
    logic m_ready = m_run && !m_done && (q.size() < DEPTH);
    logic m_pass  = m_done && (m_miss == 0) && !m_under;
    return {16'(m_match), 16'(m_miss), m_under, m_done, m_pass, m_ready};
  endfunction

  function automatic logic [35:0] dut_status();
    return {num_matches, num_miss_matches, underflow, done, pass, bus.stim_ready};
  endfunction

  function automatic logic [8:0] head_or(input logic [8:0] alt);
    return (q.size() > 0) ? q[0] : alt;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stim_valid = 1'b0;
    bus.rsp_valid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_match = 0; m_miss = 0; m_under = 0; m_done = 0; m_run = 0;
  endtask

  task automatic step(input bit sv, input logic [7:0] sa, input logic [7:0] sb, input logic [2:0] op,
                      input bit rv, input logic [8:0] res);
    bit rdy;
    logic [8:0] e;
    @(negedge clk);
    bus.stim_valid = sv; bus.a = sa; bus.b = sb; bus.opcode = op;
    bus.rsp_valid  = rv; bus.result = res;
    rdy = m_run && !m_done && (q.size() < DEPTH);
    if (m_run && !m_done) begin
      if (rv) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e == res) m_match++; else m_miss++;
        end else begin
          m_under = 1; m_miss++;
        end
      end
      if (sv && rdy) q.push_back(ref_alu(sa, sb, op));
      if (m_match + m_miss >= COUNT) m_done = 1;
    end
    m_run = 1;
    @(posedge clk);
    #1;
    bus.stim_valid = 1'b0;
    bus.rsp_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_status() !== 36'h0) begin
      errors++; $display("FAIL reset_idle got %h exp %h", dut_status(), 36'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.stim_ready !== 1'b1) begin
      errors++; $display("FAIL reset_to_run ready got %b exp 1", bus.stim_ready);
    end
  endtask

  task automatic test_directed();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'hFF, 8'h01, 3'b000, 0, 0);
    step(0, 0, 0, 0, 1, 9'h100);
    checks++;
    if (num_matches !== 16'd1 || num_miss_matches !== 16'd0) begin
      errors++; $display("FAIL add_carry got %0d/%0d exp 1/0", num_matches, num_miss_matches);
    end
    step(1, 8'h00, 8'h01, 3'b001, 0, 0);
    step(1, 8'h00, 8'h01, 3'b001, 1, 9'h1FF);
    checks++;
    if (num_matches !== 16'd2 || num_miss_matches !== 16'd0) begin
      errors++; $display("FAIL sub_borrow_match got %0d/%0d exp 2/0", num_matches, num_miss_matches);
    end
    step(0, 0, 0, 0, 1, 9'h0FF);
    checks++;
    if (num_miss_matches !== 16'd1 || dut_status() !== m_status()) begin
      errors++; $display("FAIL sub_borrow_miss got %h exp %h", dut_status(), m_status());
    end
  endtask

  task automatic test_full();
    int acc = 0;
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        checks++;
        if (bus.stim_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready got %b exp 0", bus.stim_ready);
        end
      end
      if (bus.stim_ready === 1'b1) acc++;
      step(1, 8'(i), 8'd3, 3'(i), 0, 0);
    end
    checks++;
    if (acc != DEPTH) begin
      errors++; $display("FAIL full_accepts got %0d exp %0d", acc, DEPTH);
    end
    step(0, 0, 0, 0, 1, head_or(0));
    checks++;
    if (bus.stim_ready !== 1'b1 || dut_status() !== m_status()) begin
      errors++; $display("FAIL full_drain got %h exp %h", dut_status(), m_status());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9'h055);
    checks++;
    if (underflow !== 1'b1 || num_miss_matches !== 16'd1) begin
      errors++; $display("FAIL underflow got u=%b miss=%0d exp u=1 miss=1", underflow, num_miss_matches);
    end
    step(1, 8'h12, 8'h34, 3'd0, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 8'(i * 7), 8'(i), 3'(i), 1, head_or(0));
    step(0, 0, 0, 0, 1, head_or(0));
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || dut_status() !== m_status()) begin
      errors++; $display("FAIL underflow_done got %h exp %h", dut_status(), m_status());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'hA5, 8'h5A, 3'd4, 0, 0);
    for (int i = 0; i < 15; i++)
      step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1, head_or(0));
    step(0, 0, 0, 0, 1, head_or(0));
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || num_matches !== 16'd16) begin
      errors++; $display("FAIL stream_done got d=%b p=%b m=%0d exp 1 1 16", done, pass, num_matches);
    end
    for (int i = 0; i < 3; i++) step(1, 8'd1, 8'd2, 3'd0, 1, 9'h1AB);
    checks++;
    if (dut_status() !== {16'd16, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL done_ignores got %h exp %h", dut_status(), {16'd16, 16'd0, 4'b0110});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'd10, 8'd20, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 8'd9, 3'd3, 1, head_or(0));
    step(1, 8'd1, 8'd1, 3'd0, 0, 0);
    step(1, 8'd2, 8'd2, 3'd0, 1, head_or(0));
    checks++;
    if (q.size() != 2 || dut_status() !== m_status()) begin
      errors++; $display("FAIL pre_reset got %h exp %h q=%0d", dut_status(), m_status(), q.size());
    end
    do_reset();
    checks++;
    if (dut_status() !== 36'h0) begin
      errors++; $display("FAIL mid_reset got %h exp %h", dut_status(), 36'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9'h002);
    checks++;
    if (underflow !== 1'b1 || num_matches !== 16'd0 || num_miss_matches !== 16'd1) begin
      errors++; $display("FAIL no_residual got u=%b m=%0d x=%0d exp 1 0 1", underflow, num_matches, num_miss_matches);
    end
    step(1, 8'd7, 8'd0, 3'd5, 0, 0);
    step(0, 0, 0, 0, 1, 9'h0F8);
    checks++;
    if (num_matches !== 16'd1) begin
      errors++; $display("FAIL after_reset_match got %0d exp 1", num_matches);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 60; i++) begin
        bit sv = ($urandom % 4) != 0;
        bit rv = (q.size() > 0) ? (($urandom % 2) != 0) : (($urandom % 16) == 0);
        logic [8:0] res = (($urandom % 5) != 0) ? head_or(9'($urandom)) : 9'($urandom);
        step(sv, 8'($urandom), 8'($urandom), 3'($urandom), rv, res);
        checks++;
        if (dut_status() !== m_status()) begin
          errors++; $display("FAIL random r%0d c%0d got %h exp %h", r, i, dut_status(), m_status());
        end
      end
    end
  endtask

  initial begin
    bus.stim_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;
    bus.rsp_valid  = 1'b0; bus.result = '0;
    test_reset();
    test_directed();
    test_full();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
